// File: rtl/vram_scan_arbiter_if.sv
// Pixel-writer handshake bundle between the drawing logic and the VRAM arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: the writer holds wr_x/wr_y/wr_data stable while wr_valid=1 and wr_ready=0.
interface vram_scan_arbiter_if #(
    parameter int DATA_W = 12
);
    logic              wr_valid;
    logic              wr_ready;
    logic [9:0]        wr_x;
    logic [9:0]        wr_y;
    logic [DATA_W-1:0] wr_data;
    logic              wr_oob;

    // Drawing logic side
    modport master (
        output wr_valid, wr_x, wr_y, wr_data,
        input  wr_ready, wr_oob
    );

    // Arbiter side
    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data,
        output wr_ready, wr_oob
    );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Time-shares the framebuffer RAM: slot 0 scanout read, slots 1-3 writer or clear engine.
// Latency: pix_data follows the slot-0 fetch by exactly one pixel period (4 clocks).
// Backpressure: wr_ready is low in slot 0, during a clear and in reset.
module vram_scan_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    output logic                 pix_ce,
    input  logic                 scan_active,
    input  logic [9:0]           scan_x,
    input  logic [9:0]           scan_y,
    output logic [DATA_W-1:0]    pix_data,
    vram_scan_arbiter_if.slave   wr,
    input  logic                 clr_start,
    input  logic [DATA_W-1:0]    clr_color,
    output logic                 clr_busy,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);
    localparam logic [1:0]        SLOT_SCAN  = 2'd0;
    localparam logic [1:0]        SLOT_FETCH = 2'd1;
    localparam logic [1:0]        SLOT_LAST  = 2'd3;
    localparam logic [ADDR_W-1:0] CLR_LAST   = ADDR_W'(H_RES * V_RES - 1);

    logic [1:0]        slot;
    logic              fetch_flag;
    logic [DATA_W-1:0] fetch_q;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_in_range;
    logic              wr_fire;
    logic              clr_wr;

    assign scan_addr   = ADDR_W'(scan_y) * ADDR_W'(H_RES) + ADDR_W'(scan_x);
    assign wr_addr     = ADDR_W'(wr.wr_y) * ADDR_W'(H_RES) + ADDR_W'(wr.wr_x);
    assign wr_in_range = (wr.wr_x < 10'(H_RES)) && (wr.wr_y < 10'(V_RES));

    assign pix_ce      = (slot == SLOT_LAST) && !rst;
    assign wr.wr_ready = (slot != SLOT_SCAN) && !clr_busy && !rst;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign clr_wr      = clr_busy && (slot != SLOT_SCAN) && !rst;

    // Free-running 4-slot pixel period, restarting at slot 0 out of reset
    always_ff @(posedge clk_100mhz) begin
        if (rst) slot <= SLOT_SCAN;
        else     slot <= slot + 2'd1;
    end

    // Scanout pipeline: flag in slot 0, RAM data in slot 1, present on the pix_ce edge
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            fetch_flag <= 1'b0;
            fetch_q    <= '0;
            pix_data   <= '0;
        end else begin
            if (slot == SLOT_SCAN)  fetch_flag <= scan_active;
            if (slot == SLOT_FETCH) fetch_q    <= fetch_flag ? ram_rdata : '0;
            if (slot == SLOT_LAST)  pix_data   <= fetch_q;
        end
    end

    // Out-of-range writes complete the handshake but only raise a one-cycle flag
    always_ff @(posedge clk_100mhz) begin
        if (rst) wr.wr_oob <= 1'b0;
        else     wr.wr_oob <= wr_fire && !wr_in_range;
    end

    // Clear engine: one write per writer slot, stops after the last pixel address
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            clr_busy    <= 1'b0;
            clr_cnt     <= '0;
            clr_color_q <= '0;
        end else if (!clr_busy) begin
            if (clr_start) begin
                clr_busy    <= 1'b1;
                clr_cnt     <= '0;
                clr_color_q <= clr_color;
            end
        end else if (clr_wr) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) clr_busy <= 1'b0;
        end
    end

    // RAM port mux: scanout owns slot 0 outright, clear beats the writer elsewhere
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (slot == SLOT_SCAN) begin
                if (scan_active) begin
                    ram_en   = 1'b1;
                    ram_addr = scan_addr;
                end
            end else if (clr_busy) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = clr_color_q;
            end else if (wr_fire && wr_in_range) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = wr_addr;
                ram_wdata = wr.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter on an 8x4 framebuffer with a behavioural RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_vram_scan_arbiter;
    localparam int H_RES  = 8;
    localparam int V_RES  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 12;

    logic              clk_100mhz = 1'b0;
    logic              rst;
    logic              pix_ce;
    logic              scan_active;
    logic [9:0]        scan_x;
    logic [9:0]        scan_y;
    logic [DATA_W-1:0] pix_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    vram_scan_arbiter_if #(.DATA_W(DATA_W)) wr_bus ();

    vram_scan_arbiter #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .scan_active(scan_active),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .pix_data   (pix_data),
        .wr         (wr_bus.slave),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Single-port synchronous RAM, one-cycle read latency
    logic [DATA_W-1:0] mem [0:31];
    always @(posedge clk_100mhz) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int wcnt;
    bit done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; slot model advances with it
    task automatic tick();
        @(negedge clk_100mhz);
        cyc_n = cyc_n + 1;
    endtask

    task automatic wait_slot(input int s);
        do tick(); while ((cyc_n % 4) != s);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ram_rdata = '0;
        rst = 1'b1;
        scan_active = 1'b1; scan_x = 10'd2; scan_y = 10'd1;
        clr_start = 1'b1; clr_color = 12'h123;
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd1; wr_bus.wr_y = 10'd1; wr_bus.wr_data = 12'h555;

        // 1: reset state and slot cadence
        @(negedge clk_100mhz); #1;
        chk("rst_pix_ce",   32'(pix_ce),        32'd0);
        chk("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
        chk("rst_ram_en",   32'(ram_en),        32'd0);
        chk("rst_ram_we",   32'(ram_we),        32'd0);
        chk("rst_pix_data", 32'(pix_data),      32'd0);
        chk("rst_wr_oob",   32'(wr_bus.wr_oob), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy),      32'd0);
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst = 1'b0; cyc_n = 0;
        scan_active = 1'b0; clr_start = 1'b0; wr_bus.wr_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) tick();
            #1;
            chk("cad_pix_ce",   32'(pix_ce),          32'((c % 4) == 3));
            chk("cad_wr_ready", 32'(wr_bus.wr_ready), 32'((c % 4) != 0));
        end
        chk("post_rst_busy", 32'(clr_busy), 32'd0);

        // 2: writer request raised in slot 0 lands in slot 1
        wait_slot(0);
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd2; wr_bus.wr_y = 10'd1; wr_bus.wr_data = 12'hABC;
        #1;
        chk("w_s0_ready", 32'(wr_bus.wr_ready), 32'd0);
        chk("w_s0_we",    32'(ram_we),          32'd0);
        tick(); #1;
        chk("w_s1_ready", 32'(wr_bus.wr_ready), 32'd1);
        chk("w_s1_en",    32'(ram_en),          32'd1);
        chk("w_s1_we",    32'(ram_we),          32'd1);
        chk("w_s1_addr",  32'(ram_addr),        32'd10);
        chk("w_s1_wdata", 32'(ram_wdata),       32'hABC);
        tick(); wr_bus.wr_valid = 1'b0; #1;
        chk("w_oob_inrange", 32'(wr_bus.wr_oob), 32'd0);
        chk("w_mem10",       32'(mem[10]),       32'hABC);

        // 3: scanout fetch and one-pixel-period latency
        wait_slot(0);
        scan_active = 1'b1; scan_x = 10'd2; scan_y = 10'd1; #1;
        chk("s_en",   32'(ram_en),   32'd1);
        chk("s_we",   32'(ram_we),   32'd0);
        chk("s_addr", 32'(ram_addr), 32'd10);
        tick(); scan_active = 1'b0;
        tick();
        tick(); #1;
        chk("s_pix_before", 32'(pix_data), 32'd0);
        tick(); #1;
        chk("s_idle_en", 32'(ram_en),   32'd0);
        chk("s_pix",     32'(pix_data), 32'hABC);
        wait_slot(0); #1;
        chk("s_pix_blank", 32'(pix_data), 32'd0);

        // 4: out-of-range write completes without touching RAM
        wait_slot(1);
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd8; wr_bus.wr_y = 10'd0; wr_bus.wr_data = 12'h321;
        #1;
        chk("oob_ready", 32'(wr_bus.wr_ready), 32'd1);
        chk("oob_we",    32'(ram_we),          32'd0);
        chk("oob_en",    32'(ram_en),          32'd0);
        chk("oob_flag0", 32'(wr_bus.wr_oob),   32'd0);
        tick(); wr_bus.wr_valid = 1'b0; #1;
        chk("oob_flag1", 32'(wr_bus.wr_oob), 32'd1);
        tick(); #1;
        chk("oob_flag2", 32'(wr_bus.wr_oob), 32'd0);

        // 5: full clear, writer held off, restart request ignored
        wait_slot(1);
        clr_start = 1'b1; clr_color = 12'h00F; #1;
        chk("clr_idle", 32'(clr_busy), 32'd0);
        wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd0; wr_bus.wr_y = 10'd0; wr_bus.wr_data = 12'hFFF;
        wcnt = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            clr_start = (i == 20);
            clr_color = (i == 20) ? 12'hF00 : 12'h00F;
            #1;
            if (wcnt == 32) begin
                chk("clr_fall", 32'(clr_busy), 32'd0);
                wr_bus.wr_valid = 1'b0;
                done = 1'b1;
            end else begin
                chk("clr_busy",  32'(clr_busy),        32'd1);
                chk("clr_ready", 32'(wr_bus.wr_ready), 32'd0);
                if (ram_we) begin
                    chk("clr_slot",  32'((cyc_n % 4) != 0), 32'd1);
                    chk("clr_addr",  32'(ram_addr),  32'(wcnt));
                    chk("clr_wdata", 32'(ram_wdata), 32'h00F);
                    wcnt++;
                end
            end
        end
        clr_start = 1'b0;
        wr_bus.wr_valid = 1'b0;
        chk("clr_count", 32'(wcnt), 32'd32);
        chk("clr_done",  32'(done), 32'd1);

        // 6: reset aborts a clear after its 10th write
        wait_slot(1);
        clr_start = 1'b1; clr_color = 12'h0F0;
        tick(); clr_start = 1'b0;
        wcnt = 0;
        for (int i = 0; i < 100 && wcnt < 10; i++) begin
            if (i != 0) tick();
            #1;
            if (ram_we) begin
                chk("ab_addr",  32'(ram_addr),  32'(wcnt));
                chk("ab_wdata", 32'(ram_wdata), 32'h0F0);
                wcnt++;
            end
        end
        chk("ab_count", 32'(wcnt), 32'd10);
        tick(); rst = 1'b1; #1;
        chk("ab_rst_we", 32'(ram_we), 32'd0);
        tick(); rst = 1'b0; cyc_n = 0; #1;
        chk("ab_busy", 32'(clr_busy), 32'd0);
        chk("ab_we",   32'(ram_we),   32'd0);
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            chk("ab_post_we",   32'(ram_we),   32'd0);
            chk("ab_post_busy", 32'(clr_busy), 32'd0);
        end
        chk("ab_mem10", 32'(mem[10]), 32'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the directed sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vram_scan_arbiter.md
Name: vram_scan_arbiter

Overview:
- Owns the single-port framebuffer RAM behind the VGA output and time-shares it between two users:
  - display scanout: fixed deadline, highest priority;
  - pixel writer: valid/ready handshake, plus a built-in full-screen clear engine.
- Divides the 100 MHz system clock into a 4-slot pixel period. It generates the 25 MHz pixel enable that the VGA timing generator advances on.
- Sits between the timing generator, the drawing logic and the RAM, inside the VGA top level.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DATA_W, 12, pixel width (4:4:4 RGB).

Ports:
- clk_100mhz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_ce  out  1  pixel enable, one cycle in four.
- scan_active  in  1  display-enable for the pixel being fetched.
- scan_x  in  10  scanout column.
- scan_y  in  10  scanout row.
- pix_data  out  DATA_W  registered pixel to the VGA DAC pins.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer accept.
- wr_x  in  10  write column.
- wr_y  in  10  write row.
- wr_data  in  DATA_W  write pixel.
- wr_oob  out  1  one-cycle pulse: an accepted write was out of range.
- clr_start  in  1  start full-screen clear.
- clr_color  in  DATA_W  clear colour, sampled on the start cycle.
- clr_busy  out  1  clear in progress.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.

Behaviour:
- Slot counter:
  - 2-bit, 0..3, wraps; 0 in the first cycle after rst deasserts.
  - pix_ce=1 exactly when slot==3.
- Address: y*H_RES+x, computed at ADDR_W bits.
- RAM outputs are combinational from the current slot and requests.
- Slot 0 (scan):
  - If scan_active=1: ram_en=1, ram_we=0, address from scan_x/scan_y.
  - Otherwise ram_en=0; the slot is never given to the writer.
  - scan_active is captured in slot 0 as a fetch flag.
- Slot 1: ram_rdata is captured into the fetch register, or 0 if the flag is clear.
- pix_data:
  - Loads the fetch register on the edge ending slot 3, i.e. on the pix_ce cycle.
  - Latency is exactly one pixel period. The timing generator delays hsync/vsync by one pix_ce to match.
- Writer slots 1-3:
  - wr_ready = (slot!=0) && !clr_busy && !rst.
  - A transfer occurs when wr_valid&&wr_ready.
  - In range (x<H_RES, y<V_RES): ram_en=ram_we=1 in the same cycle with the address and wr_data.
  - Out of range: the transfer still completes, no RAM access, wr_oob=1 in the next cycle.
  - Writer inputs must hold stable while wr_valid=1 and wr_ready=0.
- Clear engine:
  - clr_start while idle: clr_busy=1 from the next cycle; clr_color latched; counter starts at 0.
  - Each writer slot while busy: one write of clr_color to the counter address, then counter +1.
  - clr_busy drops in the cycle after the write to H_RES*V_RES-1.
  - clr_start while busy is ignored.
  - Slot 0 scan reads continue during a clear.
- Simultaneous clr_start and writer transfer in a writer slot: the transfer completes; the clear takes effect next cycle.
- Reset:
  - Values: pix_ce=0, pix_data=0, wr_ready=0, wr_oob=0, clr_busy=0, ram_en=0, ram_we=0, slot=0, fetch register=0.
  - rst mid-clear aborts the clear: no further writes; clr_busy=0 the next cycle.

Test Plan:
1. rst held 3 cycles, then released:
   - All outputs 0 during reset.
   - pix_ce high in post-reset cycles 3, 7, 11, counting the first post-reset cycle as 0.
   - wr_ready low in cycles 0, 4, 8.
2. H_RES=8, V_RES=4; wr_valid with x=2, y=1, data=0xABC raised in slot 0:
   - wr_ready low in slot 0.
   - In slot 1: ram_we=1, ram_addr=10, ram_wdata=0xABC; transfer completes.
3. RAM[10]=0xABC; scan_active=1, x=2, y=1 in slot 0:
   - ram_en=1, ram_we=0, ram_addr=10 in slot 0.
   - pix_data=0xABC after that group's pix_ce.
   - Next group with scan_active=0: ram_en=0 in slot 0, pix_data=0x000.
4. Write with x=8, y=0 (H_RES=8):
   - wr_ready=1 and the transfer completes; ram_we stays 0.
   - wr_oob=1 for exactly one cycle.
5. H_RES=8, V_RES=4; clr_start with clr_color=0x00F:
   - Exactly 32 ram_we pulses, addresses 0..31 in order, all data 0x00F.
   - No writes in slot 0; wr_ready=0 throughout.
   - clr_busy falls the cycle after the write to address 31; a clr_start mid-clear has no effect.
6. rst asserted after the 10th clear write:
   - clr_busy=0 and ram_we=0 the next cycle; no further writes after release.
